wam_score: RTL and testbench
============================

// Module: wam_score
// PURPOSE
//   Whac-A-Mole game scorer and round timer. Counts hit/miss events in packed
//   BCD (3 digits, 000-999), runs a BCD countdown of GAME_SEC seconds and keeps
//   the session best score. Feeds the 12-bit score bus of the digit-tube
//   display stage; sits downstream of the mole/button logic.
// PARAMETERS
//   HIT_PTS   1   BCD points added per hit, legal 1-9
//   MISS_PTS  1   BCD points subtracted per miss, legal 0-9 (0 = no penalty)
//   GAME_SEC  60  round length in seconds, integer 1-99, converted to BCD internally
// PORTS
//   clk        in   1   system clock, single clock domain
//   rst_n      in   1   synchronous reset, active low
//   tick_1hz   in   1   one-cycle pulse once per second, synchronous to clk
//   start      in   1   level from start switch; rising edge starts a round
//   hit        in   1   level, high while a whack lands on a lit mole
//   miss       in   1   level, high while a whack lands on an empty hole
//   score      out  12  BCD {hundreds,tens,ones} of the current round
//   best       out  12  BCD best final score since reset
//   time_left  out  8   BCD {tens,ones} seconds remaining
//   playing    out  1   high in PLAY
//   over       out  1   high in OVER
// BEHAVIOUR
//   Reset (rst_n low at posedge): state IDLE, score=12'h000, best=12'h000,
//     time_left=BCD(GAME_SEC), playing=0, over=0, all edge-detect regs cleared.
//     Reset mid-round aborts the round with no best update.
//   Edge detect: start/hit/miss each registered once; event = x & ~x_q.
//     Holding a level high counts exactly once.
//   Latency: register updates on the posedge where the event is true; outputs
//     change 1 cycle after the input is first sampled high.
//   States:
//     IDLE -> PLAY on start edge: score<=0, time_left<=BCD(GAME_SEC).
//     PLAY: hit edge: score+=HIT_PTS, saturate at 999.
//           miss edge: score-=MISS_PTS, floor at 000.
//           hit and miss edges in same cycle: hit applied, miss dropped.
//           tick: time_left-=1 (BCD borrow ones->tens).
//           tick while time_left==01 -> time_left<=00, go OVER.
//           start edge in PLAY: ignored.
//     OVER -> PLAY on start edge: score<=0, time reload; best kept.
//           hit/miss/tick ignored; score and time_left hold.
//   Best update: on the PLAY->OVER transition cycle, best<=max(best, final
//     score), where final score includes any hit/miss edge from that same cycle.
//   BCD arithmetic: per-digit add/sub with +6/-6 correction, carry/borrow
//     rippled over 3 digits in one cycle. Every digit of every output stays in
//     0-9 at all times; no A-F codes on score, best or time_left.
//   Compare for best is numeric on BCD (digit-wise, MSD first).
//   tick outside PLAY: no effect. Events in IDLE: no effect.
// TESTING
//   1 Reset, start pulse, 3 separate hit pulses -> score 12'h003, playing=1,
//     time_left 8'h60.
//   2 Hit held high 20 cycles -> score increments once only.
//   3 Preload score to 12'h999 via 999 hits, then one more hit -> stays 12'h999.
//     Score 12'h000 plus miss -> stays 12'h000.
//     Score 12'h010, miss, MISS_PTS=1 -> 12'h009.
//   4 60 ticks, hit on same cycle as last tick with score 12'h041 and best
//     12'h030 -> time_left 8'h00, over=1, score 12'h042, best 12'h042.
//   5 Second round ending at 12'h005 -> best stays 12'h042.
//     hit/tick in OVER -> no change.
//   6 rst_n low mid-round at score 12'h017 -> next cycle IDLE, all outputs at
//     reset values. Simultaneous hit+miss edges -> only +HIT_PTS.

Source files
------------

// File: rtl/wam_score.sv
// Whac-A-Mole scorer and round timer: packed-BCD score with saturation,
// BCD countdown of GAME_SEC seconds and the session best score.
module wam_score #(
   parameter int HIT_PTS  = 1,
   parameter int MISS_PTS = 1,
   parameter int GAME_SEC = 60
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_1hz,
   input  logic        start,
   input  logic        hit,
   input  logic        miss,
   output logic [11:0] score,
   output logic [11:0] best,
   output logic [7:0]  time_left,
   output logic        playing,
   output logic        over
);

   localparam logic [7:0] GAME_BCD = {4'(GAME_SEC / 10), 4'(GAME_SEC % 10)};
   localparam logic [3:0] HIT_D    = 4'(HIT_PTS);
   localparam logic [3:0] MISS_D   = 4'(MISS_PTS);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t      state, state_nxt;
   logic        start_q, hit_q, miss_q;
   logic        start_e, hit_e, miss_e;
   logic [11:0] score_nxt, best_nxt;
   logic [7:0]  time_nxt;

   // Add a single digit to the 3-digit BCD value; carry out of the MSD saturates to 999.
   function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [3:0] d);
      logic [4:0]  s;
      logic        c;
      logic [11:0] r;
      c = 1'b0;
      r = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         s = {1'b0, a[4*i +: 4]} + {1'b0, ((i == 0) ? d : 4'd0)} + {4'd0, c};
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return c ? 12'h999 : r;
   endfunction

   // Subtract a single digit; borrow out of the MSD floors the result at 000.
   function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [3:0] d);
      logic [4:0]  s;
      logic        b;
      logic [11:0] r;
      b = 1'b0;
      r = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         s = {1'b0, a[4*i +: 4]} - {1'b0, ((i == 0) ? d : 4'd0)} - {4'd0, b};
         if (s[4]) begin
            s = s - 5'd6;
            b = 1'b1;
         end else begin
            b = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return b ? '0 : r;
   endfunction

   function automatic logic [7:0] bcd_dec2(input logic [7:0] t);
      if (t[3:0] == 4'd0)
         return {t[7:4] - 4'd1, 4'd9};
      else
         return {t[7:4], t[3:0] - 4'd1};
   endfunction

   assign start_e = start & ~start_q;
   assign hit_e   = hit & ~hit_q;
   assign miss_e  = miss & ~miss_q;

   always_comb begin
      state_nxt = state;
      score_nxt = score;
      best_nxt  = best;
      time_nxt  = time_left;
      case (state)
         IDLE, OVER: begin
            if (start_e) begin
               state_nxt = PLAY;
               score_nxt = '0;
               time_nxt  = GAME_BCD;
            end
         end
         PLAY: begin
            if (hit_e)
               score_nxt = bcd_add(score, HIT_D);
            else if (miss_e)
               score_nxt = bcd_sub(score, MISS_D);
            if (tick_1hz) begin
               if (time_left == 8'h01) begin
                  time_nxt  = '0;
                  state_nxt = OVER;
                  // Valid BCD orders the same as plain binary, so a direct compare is digit-wise MSD first.
                  if (score_nxt > best)
                     best_nxt = score_nxt;
               end else begin
                  time_nxt = bcd_dec2(time_left);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         score     <= '0;
         best      <= '0;
         time_left <= GAME_BCD;
         start_q   <= 1'b0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         score     <= score_nxt;
         best      <= best_nxt;
         time_left <= time_nxt;
         start_q   <= start;
         hit_q     <= hit;
         miss_q    <= miss;
      end
   end

   assign playing = (state == PLAY);
   assign over    = (state == OVER);

endmodule

// File: tb/tb_wam_score.sv
// Self-checking bench for wam_score: integer reference model compared every
// cycle, directed game scenarios with literal expectations, then random play.
module tb_wam_score;

   localparam int HIT_P  = 1;
   localparam int MISS_P = 1;
   localparam int GSEC   = 60;

   logic        clk = 1'b0;
   logic        rst_n, tick_1hz, start, hit, miss;
   logic [11:0] score, best;
   logic [7:0]  time_left;
   logic        playing, over;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Reference model: plain integers, state 0=idle 1=play 2=over
   int m_st, m_sc, m_bs, m_tl;
   bit m_sq, m_hq, m_mq;

   wam_score #(.HIT_PTS(HIT_P), .MISS_PTS(MISS_P), .GAME_SEC(GSEC)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .start(start),
      .hit(hit), .miss(miss), .score(score), .best(best),
      .time_left(time_left), .playing(playing), .over(over)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] bcd3(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit se, he, me;
      if (!rst_n) begin
         m_st = 0; m_sc = 0; m_bs = 0; m_tl = GSEC;
         m_sq = 0; m_hq = 0; m_mq = 0;
      end else begin
         se = start & ~m_sq;
         he = hit & ~m_hq;
         me = miss & ~m_mq;
         if (m_st == 1) begin
            if (he)      m_sc = (m_sc + HIT_P > 999) ? 999 : m_sc + HIT_P;
            else if (me) m_sc = (m_sc - MISS_P < 0) ? 0 : m_sc - MISS_P;
            if (tick_1hz) begin
               m_tl = m_tl - 1;
               if (m_tl == 0) begin
                  m_st = 2;
                  if (m_sc > m_bs) m_bs = m_sc;
               end
            end
         end else if (se) begin
            m_st = 1; m_sc = 0; m_tl = GSEC;
         end
         m_sq = start; m_hq = hit; m_mq = miss;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_score", score, bcd3(m_sc));
         chk("model_best", best, bcd3(m_bs));
         chk("model_time", {4'd0, time_left}, {4'd0, 8'(bcd3(m_tl))});
         chk("model_playing", {11'd0, playing}, {11'd0, m_st == 1});
         chk("model_over", {11'd0, over}, {11'd0, m_st == 2});
      end
   end

   task automatic step();
      @(negedge clk);
   endtask
   task automatic hits(input int n);
      repeat (n) begin hit = 1; step(); hit = 0; step(); end
   endtask
   task automatic misses(input int n);
      repeat (n) begin miss = 1; step(); miss = 0; step(); end
   endtask
   task automatic ticks(input int n);
      repeat (n) begin tick_1hz = 1; step(); tick_1hz = 0; step(); end
   endtask
   task automatic start_pulse();
      start = 1; step(); start = 0; step();
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_score"}, score, 12'h000);
      chk({tag, "_best"}, best, 12'h000);
      chk({tag, "_time"}, {4'd0, time_left}, 12'h060);
      chk({tag, "_playing"}, {11'd0, playing}, 12'h000);
      chk({tag, "_over"}, {11'd0, over}, 12'h000);
   endtask

   initial begin
      rst_n = 0; tick_1hz = 0; start = 0; hit = 0; miss = 0;
      step(); step();
      chk_reset_vals("reset");
      cmp_en = 1;
      rst_n = 1;
      step();

      // Round A: basic scoring, edge detect, floor and saturation
      start_pulse();
      hits(3);
      chk("t1_score", score, 12'h003);
      chk("t1_playing", {11'd0, playing}, 12'h001);
      chk("t1_time", {4'd0, time_left}, 12'h060);
      hit = 1; repeat (20) step(); hit = 0; step();
      chk("t2_held_hit", score, 12'h004);
      start_pulse();
      chk("start_in_play", score, 12'h004);
      hit = 1; miss = 1; step(); hit = 0; miss = 0; step();
      chk("hit_miss_same", score, 12'h005);
      misses(5);
      chk("miss_to_zero", score, 12'h000);
      misses(1);
      chk("miss_floor", score, 12'h000);
      hits(10);
      chk("hits_to_010", score, 12'h010);
      misses(1);
      chk("miss_010", score, 12'h009);
      hits(990);
      chk("hits_to_999", score, 12'h999);
      hits(1);
      chk("hit_sat", score, 12'h999);

      // Reset mid-round
      rst_n = 0; step(); rst_n = 1; step();
      start_pulse();
      hits(17);
      chk("t6_pre", score, 12'h017);
      rst_n = 0; step();
      chk_reset_vals("midreset");
      rst_n = 1; step();

      // Round B ends at 030
      start_pulse(); hits(30); ticks(60);
      chk("rb_over", {11'd0, over}, 12'h001);
      chk("rb_best", best, 12'h030);

      // Round C: hit on the final tick counts toward best
      start_pulse(); hits(41); ticks(59);
      chk("rc_time01", {4'd0, time_left}, 12'h001);
      hit = 1; tick_1hz = 1; step(); hit = 0; tick_1hz = 0; step();
      chk("t4_time", {4'd0, time_left}, 12'h000);
      chk("t4_over", {11'd0, over}, 12'h001);
      chk("t4_playing", {11'd0, playing}, 12'h000);
      chk("t4_score", score, 12'h042);
      chk("t4_best", best, 12'h042);

      // Round D: lower score keeps best; OVER ignores events
      start_pulse();
      chk("rd_reload", {4'd0, time_left}, 12'h060);
      hits(5); ticks(60);
      chk("t5_best", best, 12'h042);
      chk("t5_score", score, 12'h005);
      hits(1); ticks(1); misses(1);
      chk("t5_over_score", score, 12'h005);
      chk("t5_over_time", {4'd0, time_left}, 12'h000);
      chk("t5_over_flag", {11'd0, over}, 12'h001);

      // Random play
      for (int i = 0; i < 6000; i++) begin
         rst_n    = ($urandom_range(0, 1499) != 0);
         start    = ($urandom_range(0, 24) == 0);
         hit      = ($urandom_range(0, 2) == 0);
         miss     = ($urandom_range(0, 3) == 0);
         tick_1hz = ($urandom_range(0, 6) == 0);
         step();
      end
      rst_n = 1; start = 0; hit = 0; miss = 0; tick_1hz = 0;
      step();
      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
